// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x BITWIDTH storage array for pipe_fifo.
//   One synchronous write port and one combinational read port.
//   The array has no reset. The owner must not present stale entries.
// Ports:
//   clk_i    clock; writes land on posedge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data; combinational from raddr_i and array contents
module fifo_mem_2p #(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [BITWIDTH-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [BITWIDTH-1:0]        rdata_o
);

  logic [BITWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_fifo.sv
// pipe_fifo: synchronous first-word-fall-through FIFO.
//   This is the elastic buffer between pipeline stages.
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   in_valid     producer presents in_data
//   in_ready     FIFO accepts a word this cycle (~full & ~RST)
//   in_data      write data
//   out_valid    out_data holds the oldest stored word (~empty)
//   out_ready    consumer takes out_data this cycle
//   out_data     head-of-queue data, combinational read (FWFT)
//   count        occupancy 0..DEPTH
//   almost_full  count >= AFULL_LVL
//
// Handshake: a transfer happens on a side at a posedge only when both valid
// and ready are high at that edge. in_ready depends only on registered state
// and RST. out_valid depends only on registered state. Neither ready nor
// valid has a combinational path to the opposite side's handshake.
module pipe_fifo #(
  parameter int BITWIDTH  = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BITWIDTH-1:0]       in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BITWIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LVL);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  // Pointers carry one extra wrap bit. This lets full and empty be told
  // apart when the low bits match.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign in_ready  = ~full & ~RST;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Modulo-2*DEPTH subtraction falls out of the PW-bit width.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (count >= AFULL_C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE_C;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE_C;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // push already includes ~RST through in_ready, so no write lands during reset.
  fifo_mem_2p #(
    .BITWIDTH (BITWIDTH),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (out_data)
  );

endmodule

// File: tb/tb_pipe_fifo.sv
module tb_pipe_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  // clock / reset block
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, almost_full;
  logic [W-1:0] out_data;
  logic [2:0]   count;

  always #5 CLK = ~CLK;

  pipe_fifo #(.BITWIDTH(W), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  // scoreboard: expected FIFO contents, oldest first
  logic [W-1:0] exp_q[$];
  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply inputs, settle which handshakes fire from the model state
  // (not from the DUT), take the edge, then advance the model.
  task automatic drive(input bit rst, input bit iv, input logic [W-1:0] d, input bit ordy);
    bit do_push, do_pop;
    RST       = rst;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    do_push = iv && (exp_q.size() < DEPTH) && !rst;
    do_pop  = ordy && (exp_q.size() > 0);
    @(posedge CLK);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end
    #1;
  endtask

  // compare process: outputs against the model on every cycle
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() < DEPTH) && !RST));
      chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFULL));
      if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    end
  end

  logic [W-1:0] pat [4];
  logic [W-1:0] held_d;
  bit           held_v;
  bit           rv, rr, rs;
  logic [W-1:0] rd;

  initial begin
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

    // reset then idle
    drive(1, 0, 8'h00, 0);
    chk_en = 1'b1;
    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);

    // fill
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, pat[i], 0);
      if (i == 2) chk("afull_after_3", 32'(almost_full), 32'd1);
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    drive(0, 1, 8'h55, 0);
    drive(0, 1, 8'h55, 0);
    chk("hold_count", 32'(count), 32'd4);

    // drain and order
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(out_data), 32'(pat[i]));
      drive(0, 0, 8'h00, 1);
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_count", 32'(count), 32'd0);

    // refill, then pop while full with a push pending
    for (int i = 0; i < 4; i++) drive(0, 1, pat[i], 0);
    chk("sim_head", 32'(out_data), 32'h11);
    drive(0, 1, 8'h55, 1);
    chk("sim_count3", 32'(count), 32'd3);
    chk("sim_ready_back", 32'(in_ready), 32'd1);
    drive(0, 1, 8'h55, 0);
    chk("sim_count4", 32'(count), 32'd4);
    pat[0] = 8'h22; pat[1] = 8'h33; pat[2] = 8'h44; pat[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      chk("sim_order", 32'(out_data), 32'(pat[i]));
      drive(0, 0, 8'h00, 1);
    end

    // streaming through pointer wrap, 1-cycle latency
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, W'(i), 1);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_data", 32'(out_data), 32'(i));
    end
    drive(0, 0, 8'h00, 1);

    // reset mid-operation
    for (int i = 0; i < 3; i++) drive(0, 1, 8'hC0 + W'(i), 0);
    chk("mid_count3", 32'(count), 32'd3);
    drive(1, 1, 8'h77, 1);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    drive(0, 1, 8'hA5, 0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'hA5);
    drive(0, 0, 8'h00, 1);

    // randomized traffic; producer holds data until accepted
    held_v = 1'b0;
    held_d = '0;
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 63) == 0);
      if (held_v) begin
        rv = 1'b1;
        rd = held_d;
      end else begin
        rv = ($urandom_range(0, 3) != 0);
        rd = W'($urandom_range(0, 255));
      end
      rr = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (held_v && !rs) chk("producer_hold", 32'(rd), 32'(held_d));
      held_v = rv && !rs && (exp_q.size() >= DEPTH) && !(rr && exp_q.size() > 0 && 1'b0);
      held_d = rd;
      drive(rs, rv, rd, rr);
    end

    drive(0, 0, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
